// File: rtl/dmem_arb_pkg.sv
// Shared constants and the command-stage record for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, return and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters and memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DATA_W
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0, lock1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_wr_en, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_wr_en, mem_addr, mem_din
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin picker; ptr names the port that wins a tie.
// Zero latency; a lock holder excludes the other port until the lock clears.
module dmem_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  input  logic lock_vld,
  input  logic lock_port,
  output logic gnt0,
  output logic gnt1,
  output logic win
);

  logic elig0, elig1;

  assign elig0 = req0 & ~(lock_vld & lock_port);
  assign elig1 = req1 & ~(lock_vld & ~lock_port);

  assign win  = (elig0 & elig1) ? ptr : elig1;
  assign gnt0 = elig0 & ~win;
  assign gnt1 = elig1 & win;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory; gnt to rvalid is 2 cycles, 1 access/cycle.
// Requesters hold until gnt (no other backpressure); optional ownership lock under DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  logic              ptr;
  logic              lock_vld, lock_port;
  logic              pick_g0, pick_g1, win;
  logic              gnt0, gnt1, any_gnt;
  logic              rd_ret;
  cmd_t              cmd;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata_q;

  dmem_rr_pick u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .ptr       (ptr),
    .lock_vld  (lock_vld),
    .lock_port (lock_port),
    .gnt0      (pick_g0),
    .gnt1      (pick_g1),
    .win       (win)
  );

  // Grants are forced off while reset is held so nothing is accepted across the release edge.
  assign gnt0    = pick_g0 & rst_n;
  assign gnt1    = pick_g1 & rst_n;
  assign any_gnt = gnt0 | gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT_CPU;
      cmd <= '0;
    end else begin
      cmd.valid <= any_gnt;
      if (any_gnt) begin
        ptr       <= other_port(win);
        cmd.we    <= win ? bus.we1    : bus.we0;
        cmd.port  <= win;
        cmd.addr  <= win ? bus.addr1  : bus.addr0;
        cmd.wdata <= win ? bus.wdata1 : bus.wdata0;
      end
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  logic owner_req, win_lock;

  assign owner_req = lock_port ? bus.req1  : bus.req0;
  assign win_lock  = win       ? bus.lock1 : bus.lock0;

  // While locked only the owner can be granted, so any grant re-evaluates the owner's lock bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld  <= 1'b0;
      lock_port <= PORT_CPU;
    end else if (lock_vld && !owner_req) begin
      lock_vld  <= 1'b0;
    end else if (any_gnt) begin
      lock_vld  <= win_lock;
      lock_port <= win;
    end
  end
`else
  logic lock_unused;

  assign lock_vld    = 1'b0;
  assign lock_port   = PORT_CPU;
  assign lock_unused = bus.lock0 ^ bus.lock1;
`endif

  assign rd_ret = cmd.valid & ~cmd.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid0_q <= rd_ret & (cmd.port == PORT_CPU);
      rvalid1_q <= rd_ret & (cmd.port == PORT_DBG);
      if (rd_ret) begin
        rdata_q <= bus.mem_dout;
      end
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_wr_en = cmd.valid & cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_din   = cmd.wdata;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants checked inline, read returns checked by a queue-fed monitor.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam logic [31:0] V1 = 32'h1111_1111;
  localparam logic [31:0] V2 = 32'h2222_2222;
  localparam logic [31:0] VB = 32'hDEAD_BEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [1024];
  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_din;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] last_rdata = '0;
  logic        exp_wr = 1'b0;
  logic [9:0]  exp_wa = '0;
  logic [31:0] exp_wd = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_rdata = '0;
    end else begin
      chk("rvalid_onehot", {63'd0, bus.rvalid0 & bus.rvalid1}, 64'd0);
      if (bus.rvalid0 || bus.rvalid1) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rvalid_port", {63'd0, bus.rvalid1}, {63'd0, mon_e.port});
          chk("rdata", {32'd0, bus.rdata}, {32'd0, mon_e.data});
          chk("rvalid_cycle", cyc, mon_e.due);
          last_rdata = mon_e.data;
        end
      end else begin
        chk("rdata_hold", {32'd0, bus.rdata}, {32'd0, last_rdata});
      end
    end
  end

  // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                      input logic l0,
                      input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                      input logic l1,
                      input logic eg0, input logic eg1, input logic [31:0] ed);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.lock0 = l0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.lock1 = l1;
    @(negedge clk);
    chk("gnt0", {63'd0, bus.gnt0}, {63'd0, eg0});
    chk("gnt1", {63'd0, bus.gnt1}, {63'd0, eg1});
    chk("mem_wr_en", {63'd0, bus.mem_wr_en}, {63'd0, exp_wr});
    if (exp_wr) begin
      chk("mem_addr", {54'd0, bus.mem_addr}, {54'd0, exp_wa});
      chk("mem_din", {32'd0, bus.mem_din}, {32'd0, exp_wd});
    end
    exp_wr = (eg0 & w0) | (eg1 & w1);
    exp_wa = eg1 ? a1 : a0;
    exp_wd = eg1 ? d1 : d0;
    if (eg0 && !w0) exp_q.push_back('{port: 1'b0, data: ed, due: cyc + 2});
    if (eg1 && !w1) exp_q.push_back('{port: 1'b1, data: ed, due: cyc + 2});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Anything in flight when reset asserts is dropped, so its expectations go too.
  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_wr = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd1; bus.wdata0 = '0; bus.lock0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'd2; bus.wdata1 = '0; bus.lock1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", {63'd0, bus.gnt0}, 64'd0);
    chk("rst_gnt1", {63'd0, bus.gnt1}, 64'd0);
    chk("rst_mem_wr_en", {63'd0, bus.mem_wr_en}, 64'd0);
    chk("rst_mem_addr", {54'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_din", {32'd0, bus.mem_din}, 64'd0);
    chk("rst_rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
    chk("rst_rdata", {32'd0, bus.rdata}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.lock0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.lock1 = 0;
    do_reset();

    // Preload: simultaneous writes resolve 0 then 1; port 1 holds until granted.
    step(1, 1, 1, V1,    0, 1, 1, 2, V2, 0, 1, 0, 0);
    step(1, 1, 9, 32'h99, 0, 1, 1, 2, V2, 0, 0, 1, 0);
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0,  0, 1, 0, 0);

    // Port 0 write then read-back of the same word.
    step(1, 1, 5, VB, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 5, 0,  0, 0, 0, 0, 0, 0, 1, 0, VB);
    idle(); idle();

    // Both ports requesting continuously after reset alternate 0,1,0,1.
    do_reset();
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 1, 0, V1);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 1, V2);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 1, 0, V1);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 1, V2);
    idle(); idle();

    // Port 1 writes, port 0 reads the same address the next cycle.
    step(0, 0, 0, 0, 0, 1, 1, 3, 32'd7, 0, 0, 1, 0);
    step(1, 0, 3, 0, 0, 0, 0, 0, 0,     0, 1, 0, 32'd7);
    idle(); idle();

    // Read in return stage and write in command stage when reset hits; pointer left at 1.
    step(0, 0, 0, 0,         0, 1, 0, 1, 0, 0, 0, 1, V1);
    step(1, 1, 9, 32'hBAD,   0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    step(1, 0, 9, 0, 0, 1, 0, 2, 0, 0, 1, 0, 32'h99);
    step(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, V2);
    idle(); idle();

    // Port 1 requests with lock1 while port 0 contends.
`ifdef DMEM_ARB_LOCK_EN
    step(0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 1, V2);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 1, 0, 1, V2);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 1, 0, 1, V2);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 1, V2);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V1);
`else
    step(0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 1, V2);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 1, 1, 0, V1);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 1, 0, 1, V2);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0, 1, 0, V1);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, V1);
`endif
    idle(); idle(); idle();

    chk("returns_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path; port 1 is the loader/debug path.
- Arbitration is round-robin, using a per-port req/gnt handshake.
- The granted access is registered into a command stage that drives the memory's write-enable, address and data-in.
- Read data is captured into a registered return stage and sent back to the owning port.
- Fully pipelined: one access can be accepted every cycle.

Parameters:
ADDR_W, 10, word-address width driven to memory (1024 words)
DATA_W, 32, data word width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0, req1  input  1 each  access request from port 0 / port 1
we0, we1  input  1 each  1 = write, 0 = read
addr0, addr1  input  ADDR_W each  word address
wdata0, wdata1  input  DATA_W each  write data
lock0, lock1  input  1 each  hold ownership (used only with feature)
gnt0, gnt1  output  1 each  combinational grant; request accepted on this rising edge
rvalid0, rvalid1  output  1 each  read data valid, one-cycle pulse
rdata  output  DATA_W  registered read data (shared; qualified by rvalid0/rvalid1)
mem_wr_en  output  1  write enable to data memory
mem_addr  output  ADDR_W  address to data memory
mem_din  output  DATA_W  write data to data memory
mem_dout  input  DATA_W  combinational read data from data memory

Behaviour:
- Reset (async assert, sync release):
  - Priority pointer = 0; command stage invalid; return stage invalid.
  - mem_wr_en=0, mem_addr=0, mem_din=0, rvalid0/1=0, rdata=0.
  - gnt0/1 are 0 while rst_n is low.
- Requester rules:
  - Hold req/we/addr/wdata stable until its gnt is seen high.
  - May present the next request in the following cycle.
- Grant, cycle N (combinational):
  - Only req0 high → gnt0. Only req1 high → gnt1.
  - Both high → the port named by the pointer wins.
  - At most one gnt is high in any cycle.
- Accept, posedge ending N:
  - The winner's we/addr/wdata/port-id are latched into the command stage, valid=1.
  - Pointer moves to the other port (the loser gets priority next time).
  - No request → command valid=0; pointer unchanged.
- Command, cycle N+1:
  - mem_addr and mem_din come from the command registers.
  - mem_wr_en = valid & we.
  - A write commits to memory at the posedge ending N+1.
  - If valid and it is a read, mem_dout is captured into rdata at that edge, with the return port-id.
- Return, cycle N+2:
  - The rvalid of the owning port is high for exactly one cycle.
  - rdata holds until the next read return.
  - Writes produce no rvalid.
- Latency: gnt to rvalid = 2 cycles; throughput = 1 access per cycle.
- Ordering: accesses are serviced in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
  - The write commits before the read's command cycle.
- Starvation: with both ports requesting continuously, grants alternate 0,1,0,1.
- Reset mid-operation:
  - A pending command is dropped (no mem_wr_en pulse) and a pending rvalid is dropped.
  - After release, arbitration restarts with port 0 priority.
- Address width: mem_addr is exactly ADDR_W; no range checking.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro:
  - If port i is granted with lock_i=1, a lock owner is recorded.
  - While locked, only port i can be granted; the other port's req waits.
  - The lock clears at the posedge where port i is granted with lock_i=0, or when req_i is low.
  - The pointer still advances normally on each grant.
  - Reset clears the lock.
- Without the macro: lock0/lock1 are present but ignored, and there is no lock state.

Decomposition:
- Package dmem_arb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - Port-id constants PORT_CPU=0, PORT_DBG=1.
  - Typedef for the command record {valid, we, port, addr, wdata}.
- One natural sub-module: dmem_rr_pick, a combinational two-way round-robin picker.
  - Inputs: req0, req1, pointer, lock state.
  - Outputs: gnt0, gnt1, winner id.

Test Plan:
- Port 0 writes 0xDEADBEEF to 5, then reads 5 → gnt0 each cycle, mem_wr_en pulse with addr 5, then rvalid0 two cycles after the read grant with rdata=0xDEADBEEF; rvalid1 stays 0.
- Both ports hold reads to 1 and 2 for 4 cycles after reset → grant order 0,1,0,1; rvalid order matches, each 2 cycles after its grant.
- Port 1 writes 7 to addr 3; next cycle port 0 reads 3 → rvalid0 with rdata=7.
- Write granted, rst_n pulsed low in the command cycle → no mem_wr_en pulse, memory at that address unchanged; after release, the pointer gives port 0 priority.
- With DMEM_ARB_LOCK_EN:
  - Port 1 holds lock1=1 over 3 grants while req0 is high → gnt1 three times.
  - Port 1 then drops lock1 → gnt0 in the next cycle.
  - Without the macro, the same stimulus alternates grants.
